spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  Receive-side SPI slave that consumes the cs/sclk/mosi stream of the 12-bit SPI master.
//  Oversamples the three SPI lines on the system clock and reassembles each LSB-first word.
//  Presents the word on dout with a one-cycle dout_valid strobe; malformed frames raise frame_err.
//  Sits directly downstream of the master, on the same clk; it is the scoreboard-facing end of the SPI link.
// PARAMETERS
//  DATA_W       12  bits per frame, received LSB first
//  SYNC_STAGES   2  flops in each cs/sclk/mosi input synchroniser (>=2)
//  LEAD_EDGES    1  sclk falling edges ignored after cs falls, before bit 0 is sampled
// PORTS
//  clk        in   1       system clock; all logic on posedge clk
//  rst        in   1       synchronous, active-high reset
//  cs         in   1       chip select from master, active low
//  sclk       in   1       serial clock from master; idle low
//  mosi       in   1       serial data; master updates it on sclk rising edges
//  dout       out  DATA_W  last good word; holds until the next good frame
//  dout_valid out  1       one-clk pulse when dout is updated
//  frame_err  out  1       one-clk pulse on a short or overlong frame
//  busy       out  1       high from detected cs fall until frame close
// BEHAVIOUR
//  Reset values: dout=0, dout_valid=0, frame_err=0, busy=0, state=IDLE, bit count=0.
//  Synchroniser flops reset to cs=1, sclk=0, mosi=0.
//  Edge detect: compare the last sync stage with a one-cycle-delayed copy.
//   - cs_fall, cs_rise, sclk_fall are single-cycle internal strobes.
//  Sampling: mosi is sampled from the synchronised path on sclk_fall.
//   - Falling edges sit mid-bit for the master's rising-edge launch.
//  FSM states:
//   - IDLE: wait for cs_fall, then -> LEAD, busy=1, lead count=0.
//     A cs already low out of reset is ignored until a high->low edge is seen.
//   - LEAD: each sclk_fall increments the lead count. At LEAD_EDGES -> SHIFT, bit count=0.
//   - SHIFT: sclk_fall writes shreg[cnt]=mosi and increments cnt.
//     When cnt reaches DATA_W -> WAIT_CS.
//   - WAIT_CS: cs_rise -> dout<=shreg, dout_valid=1, busy=0, -> IDLE.
//     sclk_fall here (overlong frame) -> DRAIN.
//   - DRAIN: ignore sclk. cs_rise -> frame_err=1, busy=0, -> IDLE; dout unchanged.
//  Short frame: cs_rise in LEAD or SHIFT -> frame_err=1, busy=0, -> IDLE; dout unchanged.
//  Simultaneous cs_rise and sclk_fall in one cycle: cs_rise wins and that sclk edge is dropped.
//  cs_fall in a non-IDLE state cannot occur (cs_rise always precedes it); no special handling.
//  dout_valid and frame_err are mutually exclusive and never high for two consecutive cycles.
//  Latency: dout_valid/frame_err rise on the SYNC_STAGES-th clk edge after the edge that first samples cs=1.
//  Reset mid-frame: the next clk edge with rst=1 forces all reset values.
//   - The partial word is discarded; no strobe is issued.
//   - Reception resumes only after a fresh cs high->low edge.
//  Minimum sclk half-period: SYNC_STAGES+1 clk cycles.
//   - The master's 11-clk half-period meets this by a wide margin.
// TESTING
//  1. Master sends din=12'hA5C
//     -> one dout_valid pulse, dout=12'hA5C, frame_err never high, busy low after the pulse.
//  2. Back-to-back frames 12'h001 then 12'hFFF
//     -> two dout_valid pulses, dout=12'h001 then 12'hFFF, no frame_err.
//  3. Bench drives cs low, LEAD_EDGES+5 sclk periods, cs high
//     -> frame_err one pulse, dout keeps its prior value, no dout_valid.
//  4. Bench drives 14 data edges after lead-in
//     -> DRAIN entered, frame_err on cs rise, dout unchanged.
//  5. rst asserted after 6 bits of 12'h3C3, released, then a full frame 12'h7E1
//     -> no strobe for the aborted frame; dout_valid with dout=12'h7E1.
//  6. rst released while cs is held low mid-stream
//     -> no busy, no strobes until cs goes high then low again.

Source files
------------

// File: rtl/spi_slave_rx.sv
// Receive-side SPI slave: oversamples cs/sclk/mosi on clk, rebuilds LSB-first words,
// and flags short or overlong frames.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int LEAD_EDGES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int LEAD_W = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES) : 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_WAIT_CS,
        ST_DRAIN
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;
    logic [WARM_W-1:0]      r_warm;
    logic                   r_armed;

    logic w_cs_s;
    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_fall;

    state_t              r_state;
    state_t              w_state_next;
    logic [LEAD_W-1:0]   r_lead_cnt;
    logic [LEAD_W-1:0]   w_lead_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_next;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_next;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   w_dout_next;
    logic                r_dout_valid;
    logic                w_valid_next;
    logic                r_frame_err;
    logic                w_err_next;
    logic [IDX_W-1:0]    w_bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_d      <= w_cs_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // The cs chain holds its reset value until it has been refilled with real samples;
    // a cs fall only counts once a genuine high level has been observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_warm != WARM_W'(SYNC_STAGES))
                r_warm <= r_warm + 1'b1;
            if (r_warm == WARM_W'(SYNC_STAGES) && w_cs_s)
                r_armed <= 1'b1;
        end
    end

    assign w_cs_fall   = r_armed & r_cs_d & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;
    assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
    assign w_bit_idx   = r_bit_cnt[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lead_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lead_cnt   <= w_lead_next;
            r_bit_cnt    <= w_bit_next;
            r_shreg      <= w_shreg_next;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_valid_next;
            r_frame_err  <= w_err_next;
        end
    end

    // cs_rise is tested first in every state so a coincident sclk fall is dropped.
    always_comb begin
        w_state_next = r_state;
        w_lead_next  = r_lead_cnt;
        w_bit_next   = r_bit_cnt;
        w_shreg_next = r_shreg;
        w_dout_next  = r_dout;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_LEAD;
                    w_lead_next  = '0;
                end
            end
            ST_LEAD: begin
                if (w_cs_rise) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_fall) begin
                    if (r_lead_cnt == LEAD_W'(LEAD_EDGES - 1)) begin
                        w_state_next = ST_SHIFT;
                        w_bit_next   = '0;
                    end else begin
                        w_lead_next = r_lead_cnt + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_fall) begin
                    w_shreg_next[w_bit_idx] = w_mosi_s;
                    w_bit_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == CNT_W'(DATA_W - 1))
                        w_state_next = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                if (w_cs_rise) begin
                    w_dout_next  = r_shreg;
                    w_valid_next = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_fall) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_cs_rise) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a behavioural 11-clk half-period master drives
// table vectors plus reset-abort and cs-low-at-reset sequences.
module tb_spi_slave_rx;

    localparam int HALF = 11;
    localparam int LEAD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        mosi;
    logic [11:0] dout;
    logic        dout_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_errs   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_bad    = 0;
    logic prev_strobe = 1'b0;

    typedef struct {
        logic [11:0] din;
        int          ndata;
        int          exp_valid;
        int          exp_err;
        logic [11:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    spi_slave_rx dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor: tallies pulses and any overlap or back-to-back strobe.
    always @(negedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (dout_valid) n_valid <= n_valid + 1;
            if (frame_err)  n_err   <= n_err + 1;
            if ((dout_valid && frame_err) || (prev_strobe && (dout_valid || frame_err)))
                n_bad <= n_bad + 1;
            prev_strobe <= dout_valid | frame_err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [11:0] d, input int ndata);
        logic [11:0] dd;
        dd = d;
        cs = 1'b0;
        wait_clk(HALF);
        @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        for (int p = 0; p < LEAD + ndata; p++) begin
            mosi = (p >= LEAD) ? dd[(p - LEAD) % 12] : 1'b0;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
    endtask

    // Raises cs just after an edge and checks the strobe lands exactly two edges later.
    task automatic close_frame(input string name);
        cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({name, "_lat_early"}, {31'd0, dout_valid | frame_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_lat_edge"}, {31'd0, dout_valid | frame_err}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, e0, b0;

        vecs[0] = '{din: 12'hA5C, ndata: 12, exp_valid: 1, exp_err: 0, exp_dout: 12'hA5C};
        vecs[1] = '{din: 12'h001, ndata: 12, exp_valid: 1, exp_err: 0, exp_dout: 12'h001};
        vecs[2] = '{din: 12'hFFF, ndata: 12, exp_valid: 1, exp_err: 0, exp_dout: 12'hFFF};
        vecs[3] = '{din: 12'h0F0, ndata: 5,  exp_valid: 0, exp_err: 1, exp_dout: 12'hFFF};
        vecs[4] = '{din: 12'h555, ndata: 14, exp_valid: 0, exp_err: 1, exp_dout: 12'hFFF};
        vecs[5] = '{din: 12'h3C3, ndata: 12, exp_valid: 1, exp_err: 0, exp_dout: 12'h3C3};

        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check("rst_dout", {20'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 6; i++) begin
            v0 = n_valid; e0 = n_err; b0 = n_bad;
            drive_frame(vecs[i].din, vecs[i].ndata);
            close_frame($sformatf("v%0d", i));
            wait_clk(5);
            @(negedge clk);
            check($sformatf("v%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("v%0d_err_cnt", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("v%0d_overlap", i), n_bad - b0, 0);
            check($sformatf("v%0d_dout", i), {20'd0, dout}, {20'd0, vecs[i].exp_dout});
            check($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset after six data bits of 12'h3C3: partial word discarded, no strobe.
        v0 = n_valid; e0 = n_err;
        drive_frame(12'h3C3, 6);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(6);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dout", {20'd0, dout}, 32'd0);
        check("abort_strobes", (n_valid - v0) + (n_err - e0), 0);
        @(posedge clk);
        #1;
        cs = 1'b1;
        wait_clk(10);
        v0 = n_valid; e0 = n_err;
        drive_frame(12'h7E1, 12);
        close_frame("post_abort");
        wait_clk(5);
        @(negedge clk);
        check("post_abort_valid_cnt", n_valid - v0, 1);
        check("post_abort_err_cnt", n_err - e0, 0);
        check("post_abort_dout", {20'd0, dout}, 32'h7E1);
        @(posedge clk);
        #1;

        // Reset released with cs already low while sclk keeps running.
        cs = 1'b0;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        v0 = n_valid; e0 = n_err;
        for (int p = 0; p < 4; p++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        @(negedge clk);
        check("cslow_busy", {31'd0, busy}, 32'd0);
        check("cslow_strobes", (n_valid - v0) + (n_err - e0), 0);
        @(posedge clk);
        #1;
        cs = 1'b1;
        wait_clk(10);
        v0 = n_valid; e0 = n_err;
        drive_frame(12'h5A3, 12);
        close_frame("cslow_next");
        wait_clk(5);
        @(negedge clk);
        check("cslow_next_valid_cnt", n_valid - v0, 1);
        check("cslow_next_dout", {20'd0, dout}, 32'h5A3);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
